// File: rtl/mul_hazard_ctrl.sv
// Pipeline sequencer for the multi-cycle MUL unit: freezes the front end while the
// multiplier runs, detects load-use hazards and counts stall cycles.
module mul_hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              id_ex_valid,
    input  logic              id_ex_is_mul,
    input  logic              id_ex_mem_read,
    input  logic [4:0]        id_ex_rd,
    input  logic [4:0]        if_id_rs1,
    input  logic [4:0]        if_id_rs2,
    input  logic              flush,
    output logic              mul_start,
    output logic              mul_res_valid,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              stall_id_ex,
    output logic              bubble_id_ex,
    output logic              bubble_ex_mem,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;
    logic       mul_go;
    logic       load_use;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    assign mul_go   = id_ex_valid & id_ex_is_mul & ~flush;
    assign load_use = id_ex_valid & id_ex_mem_read & ~flush & (id_ex_rd != 5'd0) &
                      ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            perf_stall_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (stall_pc) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
        end
    end

    // cnt holds the BUSY cycles still to go; the last BUSY cycle sees cnt==1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (mul_go) begin
                    state_next = (MUL_LATENCY == 1) ? DONE : BUSY;
                    cnt_next   = CNT_INIT;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even though they are combinational.
    always_comb begin
        mul_start     = 1'b0;
        mul_res_valid = 1'b0;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        if (arst_n) begin
            unique case (state)
                IDLE: begin
                    if (mul_go) begin
                        mul_start     = 1'b1;
                        stall_pc      = 1'b1;
                        stall_if_id   = 1'b1;
                        stall_id_ex   = 1'b1;
                        bubble_ex_mem = 1'b1;
                    end else if (load_use) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        stall_pc      = 1'b1;
                        stall_if_id   = 1'b1;
                        stall_id_ex   = 1'b1;
                        bubble_ex_mem = 1'b1;
                    end
                end
                DONE: begin
                    mul_res_valid = 1'b1;
                    if (load_use) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_hazard_ctrl.sv
// Bench for mul_hazard_ctrl: three instances (latency 4, latency 1, 3-bit counter)
// driven by shared stimulus, directed scenarios plus a random run against a cycle model.
module tb_mul_hazard_ctrl;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       id_ex_valid, id_ex_is_mul, id_ex_mem_read, flush;
    logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;

    logic [2:0] start_o, res_o, spc_o, sif_o, sidex_o, bidex_o, bexm_o;
    logic [15:0] perf0, perf1;
    logic [2:0]  perf2;
    logic [6:0]  ov0, ov1, ov2;

    int checks = 0;
    int errors = 0;

    // Output bundle: {mul_start, mul_res_valid, stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, bubble_ex_mem}
    localparam logic [6:0] P_START  = 7'b1011101;
    localparam logic [6:0] P_FREEZE = 7'b0011101;
    localparam logic [6:0] P_DONE   = 7'b0100000;
    localparam logic [6:0] P_LU     = 7'b0011010;

    always #5 clk = ~clk;

    mul_hazard_ctrl #(.MUL_LATENCY(4), .PERF_W(16)) dut0 (
        .clk(clk), .arst_n(arst_n), .id_ex_valid(id_ex_valid), .id_ex_is_mul(id_ex_is_mul),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
        .if_id_rs2(if_id_rs2), .flush(flush), .mul_start(start_o[0]), .mul_res_valid(res_o[0]),
        .stall_pc(spc_o[0]), .stall_if_id(sif_o[0]), .stall_id_ex(sidex_o[0]),
        .bubble_id_ex(bidex_o[0]), .bubble_ex_mem(bexm_o[0]), .perf_stall_cnt(perf0));

    mul_hazard_ctrl #(.MUL_LATENCY(1), .PERF_W(16)) dut1 (
        .clk(clk), .arst_n(arst_n), .id_ex_valid(id_ex_valid), .id_ex_is_mul(id_ex_is_mul),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
        .if_id_rs2(if_id_rs2), .flush(flush), .mul_start(start_o[1]), .mul_res_valid(res_o[1]),
        .stall_pc(spc_o[1]), .stall_if_id(sif_o[1]), .stall_id_ex(sidex_o[1]),
        .bubble_id_ex(bidex_o[1]), .bubble_ex_mem(bexm_o[1]), .perf_stall_cnt(perf1));

    mul_hazard_ctrl #(.MUL_LATENCY(4), .PERF_W(3)) dut2 (
        .clk(clk), .arst_n(arst_n), .id_ex_valid(id_ex_valid), .id_ex_is_mul(id_ex_is_mul),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1),
        .if_id_rs2(if_id_rs2), .flush(flush), .mul_start(start_o[2]), .mul_res_valid(res_o[2]),
        .stall_pc(spc_o[2]), .stall_if_id(sif_o[2]), .stall_id_ex(sidex_o[2]),
        .bubble_id_ex(bidex_o[2]), .bubble_ex_mem(bexm_o[2]), .perf_stall_cnt(perf2));

    assign ov0 = {start_o[0], res_o[0], spc_o[0], sif_o[0], sidex_o[0], bidex_o[0], bexm_o[0]};
    assign ov1 = {start_o[1], res_o[1], spc_o[1], sif_o[1], sidex_o[1], bidex_o[1], bexm_o[1]};
    assign ov2 = {start_o[2], res_o[2], spc_o[2], sif_o[2], sidex_o[2], bidex_o[2], bexm_o[2]};

    function automatic logic [6:0] get_ov(input int i);
        if (i == 0) return ov0;
        if (i == 1) return ov1;
        return ov2;
    endfunction

    function automatic int get_perf(input int i);
        if (i == 0) return int'(perf0);
        if (i == 1) return int'(perf1);
        return int'(perf2);
    endfunction

    task automatic drive(input logic v, input logic m, input logic r, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic f);
        id_ex_valid = v; id_ex_is_mul = m; id_ex_mem_read = r;
        id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2; flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        drive(1, 1, 0, 5'd3, 5'd3, 5'd3, 0);
        #2;
        checks++;
        if (ov0 !== 7'd0) begin errors++; $display("FAIL reset_outs0 got %b exp %b", ov0, 7'd0); end
        checks++;
        if (ov1 !== 7'd0) begin errors++; $display("FAIL reset_outs1 got %b exp %b", ov1, 7'd0); end
        checks++;
        if (perf0 !== 16'd0) begin errors++; $display("FAIL reset_perf0 got %0d exp 0", perf0); end
        checks++;
        if (perf2 !== 3'd0) begin errors++; $display("FAIL reset_perf2 got %0d exp 0", perf2); end
        tick();
        arst_n = 1'b1;
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        checks++;
        if (ov0 !== 7'd0) begin errors++; $display("FAIL reset_idle got %b exp %b", ov0, 7'd0); end
        tick();
    endtask

    task automatic test_single_mul();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(c < 5, c < 5, 0, 5'd3, 5'd1, 5'd2, 0);
            @(negedge clk);
            exp = (c == 0) ? P_START : (c < 4) ? P_FREEZE : (c == 4) ? P_DONE : 7'd0;
            checks++;
            if (ov0 !== exp) begin errors++; $display("FAIL single_mul c=%0d got %b exp %b", c, ov0, exp); end
            tick();
        end
        checks++;
        if (perf0 !== 16'd4) begin errors++; $display("FAIL single_perf got %0d exp 4", perf0); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        int k;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive(c < 10, c < 10, 0, 5'd3, 5'd1, 5'd2, 0);
            @(negedge clk);
            k = c % 5;
            exp = (c == 10) ? 7'd0 : (k == 0) ? P_START : (k < 4) ? P_FREEZE : P_DONE;
            checks++;
            if (ov0 !== exp) begin errors++; $display("FAIL b2b c=%0d got %b exp %b", c, ov0, exp); end
            tick();
        end
        checks++;
        if (perf0 !== 16'd8) begin errors++; $display("FAIL b2b_perf got %0d exp 8", perf0); end
    endtask

    task automatic test_flush_abort();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(c < 3, c < 3, 0, 5'd3, 5'd1, 5'd2, c == 2);
            @(negedge clk);
            exp = (c == 0) ? P_START : (c == 1) ? P_FREEZE : 7'd0;
            checks++;
            if (ov0 !== exp) begin errors++; $display("FAIL flush_abort c=%0d got %b exp %b", c, ov0, exp); end
            tick();
        end
        checks++;
        if (perf0 !== 16'd2) begin errors++; $display("FAIL flush_perf got %0d exp 2", perf0); end
    endtask

    task automatic test_load_use();
        int rds[7]  = '{5, 5, 0, 5, 5, 7, 6};
        int rs1s[7] = '{0, 5, 0, 1, 5, 7, 6};
        int rs2s[7] = '{5, 0, 0, 2, 5, 3, 6};
        int fls[7]  = '{0, 0, 0, 0, 1, 0, 0};
        int vls[7]  = '{1, 1, 1, 1, 1, 1, 0};
        int hits = 0;
        logic hit;
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(vls[c] != 0, 0, 1, 5'(rds[c]), 5'(rs1s[c]), 5'(rs2s[c]), fls[c] != 0);
            @(negedge clk);
            hit = (vls[c] != 0) && (fls[c] == 0) && (rds[c] != 0) &&
                  (rds[c] == rs1s[c] || rds[c] == rs2s[c]);
            exp = hit ? P_LU : 7'd0;
            if (hit) hits++;
            checks++;
            if (ov0 !== exp) begin errors++; $display("FAIL load_use c=%0d got %b exp %b", c, ov0, exp); end
            tick();
        end
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        checks++;
        if (perf0 !== 16'(hits)) begin errors++; $display("FAIL load_use_perf got %0d exp %0d", perf0, hits); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1, 1, 0, 5'd3, 5'd1, 5'd2, 0);
            @(negedge clk);
            exp = (c == 0) ? P_START : P_FREEZE;
            checks++;
            if (ov0 !== exp) begin errors++; $display("FAIL rst_busy_pre c=%0d got %b exp %b", c, ov0, exp); end
            tick();
        end
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (ov0 !== 7'd0) begin errors++; $display("FAIL rst_busy_drop got %b exp %b", ov0, 7'd0); end
        checks++;
        if (perf0 !== 16'd0) begin errors++; $display("FAIL rst_busy_perf got %0d exp 0", perf0); end
        tick();
        tick();
        arst_n = 1'b1;
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int c = 4; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (ov0 !== 7'd0 || perf0 !== 16'd0) begin
                errors++; $display("FAIL rst_busy_post c=%0d got %b/%0d exp 0/0", c, ov0, perf0);
            end
            tick();
        end
    endtask

    task automatic test_lat1();
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(c < 2, c < 2, 0, 5'd3, 5'd1, 5'd2, 0);
            @(negedge clk);
            exp = (c == 0) ? P_START : (c == 1) ? P_DONE : 7'd0;
            checks++;
            if (ov1 !== exp) begin errors++; $display("FAIL lat1 c=%0d got %b exp %b", c, ov1, exp); end
            tick();
        end
        checks++;
        if (perf1 !== 16'd1) begin errors++; $display("FAIL lat1_perf got %0d exp 1", perf1); end
    endtask

    task automatic test_perf_sat();
        int stalls = 0;
        int exp_sat;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 10) drive(1, 1, 0, 5'd3, 5'd1, 5'd2, 0);
            else if (c == 10) drive(1, 0, 1, 5'd5, 5'd1, 5'd5, 0);
            else drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
            @(negedge clk);
            exp_sat = (stalls > 7) ? 7 : stalls;
            checks++;
            if (int'(perf2) != exp_sat) begin
                errors++; $display("FAIL perf_sat c=%0d got %0d exp %0d", c, perf2, exp_sat);
            end
            if ((c < 10 && (c % 5) < 4) || c == 10) stalls++;
            tick();
        end
        checks++;
        if (perf0 !== 16'd9) begin errors++; $display("FAIL perf_wide got %0d exp 9", perf0); end
    endtask

    task automatic test_random();
        int lat[3]  = '{4, 1, 4};
        int pmax[3] = '{65535, 65535, 7};
        int left[3] = '{0, 0, 0};
        int done[3] = '{0, 0, 0};
        int perf[3] = '{0, 0, 0};
        logic v, m, r, f, lu, go;
        logic [4:0] rd, rs1, rs2;
        logic [6:0] exp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v = ($urandom % 5) != 0;
            m = ($urandom % 4) == 0;
            r = !m && (($urandom % 3) == 0);
            rd = 5'($urandom % 4); rs1 = 5'($urandom % 4); rs2 = 5'($urandom % 4);
            f = ($urandom % 10) == 0;
            drive(v, m, r, rd, rs1, rs2, f);
            lu = v && r && !f && rd != 0 && (rd == rs1 || rd == rs2);
            go = v && m && !f;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                exp = 7'd0;
                if (done[i] != 0) begin
                    exp = lu ? (P_DONE | P_LU) : P_DONE;
                    done[i] = 0;
                end else if (left[i] > 0) begin
                    if (f) left[i] = 0;
                    else begin
                        exp = P_FREEZE;
                        left[i]--;
                        if (left[i] == 0) done[i] = 1;
                    end
                end else if (go) begin
                    exp = P_START;
                    left[i] = lat[i] - 1;
                    if (left[i] == 0) done[i] = 1;
                end else if (lu) begin
                    exp = P_LU;
                end
                checks++;
                if (get_ov(i) !== exp) begin
                    errors++; $display("FAIL rand_outs dut%0d c=%0d got %b exp %b", i, c, get_ov(i), exp);
                end
                checks++;
                if (get_perf(i) != perf[i]) begin
                    errors++; $display("FAIL rand_perf dut%0d c=%0d got %0d exp %0d", i, c, get_perf(i), perf[i]);
                end
                if (exp[4] && perf[i] < pmax[i]) perf[i]++;
            end
            tick();
        end
    endtask

    initial begin
        arst_n = 1'b0;
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        tick();
        test_reset();
        test_single_mul();
        test_back_to_back();
        test_flush_abort();
        test_load_use();
        test_reset_mid_busy();
        test_lat1();
        test_perf_sat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
